// File: rtl/bip_pkg.sv
// Shared types and constants for the BIP core: field widths, opcodes,
// accumulator-source encodings, sequencer states and the decoded control word.
package bip_pkg;

  localparam int ADDRESS_BITS = 11;
  localparam int DATA_BITS    = 16;
  localparam int OPCODE_BITS  = 5;
  localparam int COUNT_BITS   = 16;

  localparam logic [OPCODE_BITS-1:0] OP_HLT  = 5'd0;
  localparam logic [OPCODE_BITS-1:0] OP_STO  = 5'd1;
  localparam logic [OPCODE_BITS-1:0] OP_LD   = 5'd2;
  localparam logic [OPCODE_BITS-1:0] OP_LDI  = 5'd3;
  localparam logic [OPCODE_BITS-1:0] OP_ADD  = 5'd4;
  localparam logic [OPCODE_BITS-1:0] OP_ADDI = 5'd5;
  localparam logic [OPCODE_BITS-1:0] OP_SUB  = 5'd6;
  localparam logic [OPCODE_BITS-1:0] OP_SUBI = 5'd7;

  typedef enum logic [1:0] {
    SEL_A_RAM = 2'd0,
    SEL_A_IMM = 2'd1,
    SEL_A_ALU = 2'd2
  } sel_a_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  typedef struct packed {
    sel_a_e sel_a;
    logic   sel_b;
    logic   alu_sub;
    logic   wr_acc;
    logic   rd_ram;
    logic   wr_ram;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{SEL_A_RAM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  function automatic logic [DATA_BITS-1:0] sign_extend(input logic [ADDRESS_BITS-1:0] v);
    return {{OPCODE_BITS{v[ADDRESS_BITS-1]}}, v};
  endfunction

endpackage

// File: rtl/bip_control_unit_if.sv
// Instruction-fetch and control-strobe bundle between the BIP control unit
// (slave side) and the program memory / datapath that surround it (master side).
interface bip_control_unit_if;
  import bip_pkg::*;

  logic                    i_enable;
  logic [DATA_BITS-1:0]    i_instruction;
  logic [ADDRESS_BITS-1:0] o_pc_address;
  logic [ADDRESS_BITS-1:0] o_operand;
  logic [DATA_BITS-1:0]    o_imm_ext;
  logic [1:0]              o_sel_a;
  logic                    o_sel_b;
  logic                    o_alu_sub;
  logic                    o_wr_acc;
  logic                    o_rd_ram;
  logic                    o_wr_ram;
  logic                    o_halted;
  logic                    o_illegal;
  logic [COUNT_BITS-1:0]   o_instr_count;

  modport master (
    output i_enable, i_instruction,
    input  o_pc_address, o_operand, o_imm_ext, o_sel_a, o_sel_b, o_alu_sub,
           o_wr_acc, o_rd_ram, o_wr_ram, o_halted, o_illegal, o_instr_count
  );

  modport slave (
    input  i_enable, i_instruction,
    output o_pc_address, o_operand, o_imm_ext, o_sel_a, o_sel_b, o_alu_sub,
           o_wr_acc, o_rd_ram, o_wr_ram, o_halted, o_illegal, o_instr_count
  );

endinterface

// File: rtl/bip_decoder.sv
// Purely combinational opcode decoder: maps an opcode to its control word and
// flags HLT and the unused opcode space. State gating happens in the caller.
module bip_decoder
  import bip_pkg::*;
(
  input  logic [OPCODE_BITS-1:0] opcode,
  output ctrl_t                  ctrl,
  output logic                   is_hlt,
  output logic                   illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned; that is what keeps this block from inferring latches.
    ctrl    = CTRL_NOP;
    is_hlt  = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_HLT:  is_hlt = 1'b1;
      OP_STO:  ctrl.wr_ram = 1'b1;
      OP_LD: begin
        ctrl.rd_ram = 1'b1;
        ctrl.sel_a  = SEL_A_RAM;
        ctrl.wr_acc = 1'b1;
      end
      OP_LDI: begin
        ctrl.sel_a  = SEL_A_IMM;
        ctrl.wr_acc = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        ctrl.rd_ram  = 1'b1;
        ctrl.sel_a   = SEL_A_ALU;
        ctrl.sel_b   = 1'b0;
        ctrl.alu_sub = (opcode == OP_SUB);
        ctrl.wr_acc  = 1'b1;
      end
      OP_ADDI, OP_SUBI: begin
        ctrl.sel_a   = SEL_A_ALU;
        ctrl.sel_b   = 1'b1;
        ctrl.alu_sub = (opcode == OP_SUBI);
        ctrl.wr_acc  = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/bip_control_unit.sv
// BIP instruction sequencer: owns the PC, retired-instruction counter and the
// IDLE/RUN/HALT state, and gates the decoder's strobes into the datapath.
module bip_control_unit
  import bip_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  bip_control_unit_if.slave  bus
);

  state_e                  state_d, state_q;
  logic [ADDRESS_BITS-1:0] pc_d, pc_q;
  logic [COUNT_BITS-1:0]   count_d, count_q;
  logic                    illegal_d, illegal_q;

  logic [OPCODE_BITS-1:0]  opcode;
  ctrl_t                   dec_ctrl;
  ctrl_t                   ctrl;
  logic                    dec_hlt;
  logic                    dec_illegal;

  assign opcode = bus.i_instruction[DATA_BITS-1 -: OPCODE_BITS];

  bip_decoder u_decoder (
    .opcode  (opcode),
    .ctrl    (dec_ctrl),
    .is_hlt  (dec_hlt),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    illegal_d = illegal_q;
    ctrl      = CTRL_NOP;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.i_enable) begin
          ctrl = dec_ctrl;
          if (dec_hlt) begin
            state_d = ST_HALT;
          end else begin
            // PC wraps naturally at 2^ADDRESS_BITS; illegal opcodes still advance it.
            pc_d = pc_q + ADDRESS_BITS'(1);
            if (dec_illegal)          illegal_d = 1'b1;
            else if (count_q != '1)   count_d   = count_q + COUNT_BITS'(1);
          end
        end
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.o_pc_address  = pc_q;
  assign bus.o_operand     = bus.i_instruction[ADDRESS_BITS-1:0];
  assign bus.o_imm_ext     = sign_extend(bus.i_instruction[ADDRESS_BITS-1:0]);
  assign bus.o_sel_a       = ctrl.sel_a;
  assign bus.o_sel_b       = ctrl.sel_b;
  assign bus.o_alu_sub     = ctrl.alu_sub;
  assign bus.o_wr_acc      = ctrl.wr_acc;
  assign bus.o_rd_ram      = ctrl.rd_ram;
  assign bus.o_wr_ram      = ctrl.wr_ram;
  assign bus.o_halted      = (state_q == ST_HALT);
  assign bus.o_illegal     = illegal_q;
  assign bus.o_instr_count = count_q;

endmodule

// File: tb/tb_bip_control_unit.sv
// Self-checking bench for bip_control_unit: a falling-edge program memory feeds
// the DUT, a reference model queues expected outputs, a monitor pops and compares.
module tb_bip_control_unit;
  import bip_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bip_control_unit_if bus ();

  bip_control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [10:0] pc;
    logic [15:0] count;
    logic [1:0]  flags;    // {halted, illegal}
    logic [6:0]  strobes;  // {sel_a[1:0], sel_b, alu_sub, wr_acc, rd_ram, wr_ram}
    logic [10:0] operand;
    logic [15:0] imm;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [15:0] mem [2048];

  // Strobe table indexed by opcode 0..7, straight from the instruction set.
  logic [6:0] strobe_tab [8] = '{
    7'b00_0_0_0_0_0,  // HLT
    7'b00_0_0_0_0_1,  // STO
    7'b00_0_0_1_1_0,  // LD
    7'b01_0_0_1_0_0,  // LDI
    7'b10_0_0_1_1_0,  // ADD
    7'b10_1_0_1_0_0,  // ADDI
    7'b10_0_1_1_1_0,  // SUB
    7'b10_1_1_1_0_0   // SUBI
  };

  // Reference model state
  int m_pc, m_cnt;
  bit m_started, m_halted, m_ill;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int arg);
    return {op[4:0], arg[10:0]};
  endfunction

  // One clock: drive inputs on the falling edge, queue the expected outputs
  // for this half-cycle, then advance the model across the coming rising edge.
  task automatic cycle(input logic r, input logic e);
    logic [15:0] ins;
    int   op, v;
    exp_t x;
    @(negedge clk);
    rst          = r;
    bus.i_enable = e;
    ins          = mem[bus.o_pc_address];
    bus.i_instruction = ins;
    op = int'(ins[15:11]);
    if (!r) begin
      v = int'(ins[10:0]);
      if (v >= 1024) v -= 2048;
      x.pc      = 11'(m_pc);
      x.count   = 16'(m_cnt);
      x.flags   = {m_halted, m_ill};
      x.strobes = (m_started && !m_halted && e && op < 8) ? strobe_tab[op] : 7'b0;
      x.operand = ins[10:0];
      x.imm     = 16'(v);
      exp_q.push_back(x);
    end
    if (r) begin
      m_pc = 0; m_cnt = 0; m_started = 0; m_halted = 0; m_ill = 0;
    end else if (!m_started) begin
      m_started = e;
    end else if (!m_halted && e) begin
      if (op == 0) m_halted = 1;
      else begin
        m_pc = (m_pc + 1) % 2048;
        if (op >= 8) m_ill = 1;
        else if (m_cnt < 65535) m_cnt++;
      end
    end
  endtask

  task automatic expect_state(input string tag, input int pc, input int cnt,
                              input bit halted, input bit ill);
    #2;
    check({tag, "_pc"},      64'(bus.o_pc_address),  64'(pc));
    check({tag, "_count"},   64'(bus.o_instr_count), 64'(cnt));
    check({tag, "_halted"},  64'(bus.o_halted),      64'(halted));
    check({tag, "_illegal"}, 64'(bus.o_illegal),     64'(ill));
  endtask

  task automatic clear_mem(input logic [15:0] fill);
    for (int i = 0; i < 2048; i++) mem[i] = fill;
  endtask

  task automatic load_main();
    clear_mem(16'h0000);
    mem[0]  = enc(3, -4);   // LDI -4
    mem[1]  = enc(1, 1);    // STO 1
    mem[2]  = enc(3, 2);    // LDI 2
    mem[3]  = enc(4, 1);    // ADD 1
    mem[4]  = enc(1, 2);    // STO 2
    mem[5]  = enc(3, 123);  // LDI 123
    mem[6]  = enc(5, 7);    // ADDI 7
    mem[7]  = enc(2, 2);    // LD 2
    mem[8]  = enc(5, 4);    // ADDI 4
    mem[9]  = enc(7, 50);   // SUBI 50
    mem[10] = enc(6, 1);    // SUB 1
    mem[11] = enc(0, 0);    // HLT
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
  endtask

  // Monitor: compares every queued expectation half a cycle after the edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("pc",      64'(bus.o_pc_address),  64'(x.pc));
        check("count",   64'(bus.o_instr_count), 64'(x.count));
        check("flags",   64'({bus.o_halted, bus.o_illegal}), 64'(x.flags));
        check("strobes", 64'({bus.o_sel_a, bus.o_sel_b, bus.o_alu_sub,
                              bus.o_wr_acc, bus.o_rd_ram, bus.o_wr_ram}), 64'(x.strobes));
        check("operand_imm", 64'({bus.o_operand, bus.o_imm_ext}), 64'({x.operand, x.imm}));
      end
    end
  end

  initial begin
    int guard, stall;
    rst = 1'b1;
    bus.i_enable = 1'b0;
    bus.i_instruction = '0;
    m_pc = 0; m_cnt = 0; m_started = 0; m_halted = 0; m_ill = 0;

    // Reset with enable high, then the full program with a 3-cycle stall at PC 5.
    load_main();
    do_reset();
    cycle(1'b0, 1'b1);
    expect_state("reset", 0, 0, 1'b0, 1'b0);
    check("reset_strobes", 64'({bus.o_wr_acc, bus.o_rd_ram, bus.o_wr_ram}), 64'(0));
    guard = 0;
    stall = 3;
    while (!m_halted && guard < 200) begin
      if (m_started && m_pc == 5 && stall > 0) begin
        cycle(1'b0, 1'b0);
        stall--;
      end else begin
        cycle(1'b0, 1'b1);
      end
      guard++;
    end
    check("prog_reached_hlt", 64'(m_halted), 64'(1));
    repeat (20) cycle(1'b0, 1'($urandom_range(0, 1)));
    expect_state("halt", 11, 11, 1'b1, 1'b0);

    // Illegal opcode at PC 3, then a reset in the middle of the run at PC 7.
    load_main();
    mem[3] = enc(8, 0);
    do_reset();
    guard = 0;
    while (m_pc != 7 && guard < 100) begin
      cycle(1'b0, 1'b1);
      guard++;
    end
    cycle(1'b1, 1'b1);
    expect_state("illegal", 7, 6, 1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    expect_state("midrst", 0, 0, 1'b0, 1'b0);

    // PC wrap: every word is ADDI 0.
    clear_mem(enc(5, 0));
    do_reset();
    cycle(1'b0, 1'b1);
    repeat (2048) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    expect_state("wrap", 0, 2048, 1'b0, 1'b0);

    // Randomized programs with random enable and occasional reset.
    for (int round = 0; round < 6; round++) begin
      for (int i = 0; i < 2048; i++) begin
        int pick;
        pick = int'($urandom_range(0, 99));
        if (pick < 3)      mem[i] = enc(0, int'($urandom));
        else if (pick < 8) mem[i] = enc(int'($urandom_range(8, 31)), int'($urandom));
        else               mem[i] = enc(int'($urandom_range(1, 7)), int'($urandom));
      end
      do_reset();
      repeat (400) cycle(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0));
    end

    repeat (3) @(negedge clk);
    #3;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bip_control_unit.md
# bip_control_unit

Instruction sequencer and decoder for the BIP core. Owns the program counter, drives the program memory address, and turns the instruction word returned by the program memory into accumulator, ALU and data-memory control strobes. It executes one instruction per cycle until it decodes `HLT`, then parks in a halted state until reset.

## Interface
- `ADDRESS_BITS`, 11, width of the PC, program-memory address and instruction operand field.
- `DATA_BITS`, 16, instruction word and datapath width.
- `OPCODE_BITS`, 5, opcode field width (`DATA_BITS = OPCODE_BITS + ADDRESS_BITS`).
- `COUNT_BITS`, 16, retired-instruction counter width.

Ports:
- `clk` in 1: single clock, rising-edge state.
- `rst` in 1: synchronous, active-high reset.
- `i_enable` in 1: run permission; low stalls without losing state.
- `i_instruction` in DATA_BITS: instruction word from the program memory `o_data`.
- `o_pc_address` out ADDRESS_BITS: program-memory address, equal to the PC register.
- `o_operand` out ADDRESS_BITS: raw `i_instruction[ADDRESS_BITS-1:0]`, data-memory address.
- `o_imm_ext` out DATA_BITS: operand sign-extended to DATA_BITS.
- `o_sel_a` out 2: accumulator source, 0 = data memory, 1 = immediate, 2 = ALU result.
- `o_sel_b` out 1: ALU operand B, 0 = data memory, 1 = immediate.
- `o_alu_sub` out 1: 0 = add, 1 = subtract.
- `o_wr_acc` out 1: accumulator write enable.
- `o_rd_ram` out 1: data-memory read enable.
- `o_wr_ram` out 1: data-memory write enable.
- `o_halted` out 1: high in HALT.
- `o_illegal` out 1: sticky flag for opcodes 8–31.
- `o_instr_count` out COUNT_BITS: retired-instruction count.

## Operation
- States are IDLE, RUN and HALT. Reset enters IDLE with PC = 0, count = 0 and `o_illegal` = 0.
- IDLE: all strobes are 0 and the PC holds. Goes to RUN on the next edge when `i_enable` = 1.
- RUN with `i_enable` = 1: decode `i_instruction[DATA_BITS-1 -: OPCODE_BITS]`:
  - `HLT` 0: no strobes, PC holds, go to HALT.
  - `STO` 1: `wr_ram`.
  - `LD` 2: `rd_ram`, `sel_a` = 0, `wr_acc`.
  - `LDI` 3: `sel_a` = 1, `wr_acc`.
  - `ADD` 4: `rd_ram`, `sel_a` = 2, `sel_b` = 0, `alu_sub` = 0, `wr_acc`.
  - `ADDI` 5: `sel_a` = 2, `sel_b` = 1, `alu_sub` = 0, `wr_acc`.
  - `SUB` 6: as `ADD` with `alu_sub` = 1.
  - `SUBI` 7: as `ADDI` with `alu_sub` = 1.
  - Opcodes 8–31: no strobes, PC advances, `o_illegal` sets, count is unchanged.
- Each legal non-`HLT` instruction increments the PC and the count at the edge.
- RUN with `i_enable` = 0: all strobes are 0 and the PC, count and state hold.
- HALT: all strobes are 0, PC and count frozen, `o_halted` = 1. Only `rst` exits.
- PC is modulo 2^ADDRESS_BITS, so 2047 + 1 wraps to 0. The counter saturates at all-ones.
- `rst` overrides everything in any state, mid-instruction included.

## Timing
- The program memory samples `o_pc_address` on the falling edge. `i_instruction` is therefore valid during the second half-cycle.
- Decode is combinational from state and `i_instruction`. Strobes are consumed by the datapath on the next rising edge, giving 1 instruction/cycle.
- IDLE→RUN costs 1 cycle. The instruction at PC 0 executes in the first RUN cycle.
- Reset values: `o_pc_address` = 0, every strobe = 0, `o_sel_a`/`o_sel_b`/`o_alu_sub` = 0, `o_halted` = 0, `o_illegal` = 0, `o_instr_count` = 0.
- `o_operand` and `o_imm_ext` are pure functions of `i_instruction` and are not gated.

## Structure
- Shared package `bip_pkg` holds:
  - opcode constants HLT…SUBI;
  - `o_sel_a` encodings `SEL_A_RAM`/`SEL_A_IMM`/`SEL_A_ALU`;
  - state encoding;
  - a packed control-word typedef.
- Sub-module `bip_decoder`: purely combinational, opcode → control word plus `illegal`. The top level gates its output with state and `i_enable`.

## Test plan
- Reset with `i_enable` = 1: PC = 0, all strobes 0, IDLE, then RUN after 1 cycle.
- Full program run:
  - Program: LDI −4, STO 1, LDI 2, ADD 1, STO 2, LDI 123, ADDI 7, LD 2, ADDI 4, SUBI 50, SUB 1, HLT.
  - Expected: PC steps 0..11. At PC 0, `o_imm_ext` = 0xFFFC with `sel_a` = 1 and `wr_acc`. At PC 3, `rd_ram`, `sel_a` = 2, `sel_b` = 0. Then halt at PC 11 with count = 11 and PC frozen for 20 more cycles.
- Stall: drop `i_enable` for 3 cycles at PC 5 → PC 5 and count 5 hold and strobes are 0. Re-raising it executes LDI 123.
- Illegal: opcode 8 at PC 3 → no strobes, PC goes to 4, `o_illegal` = 1 and stays 1, count is not incremented.
- Wrap: memory filled with ADDI 0 → after 2048 RUN cycles PC returns to 0, count = 2048.
- Mid-run reset: `rst` at PC 7 → next cycle PC = 0, IDLE, count = 0, `o_illegal` = 0.
